// File: rtl/decode_issue.sv
// Decode/issue stage: reads operands from a small register file, stalls on
// RAW/WAW hazards via a busy-bit scoreboard, and issues to execute one cycle later.
module decode_issue #(
  parameter int DATA_W = 8,
  parameter int NREG   = 16,
  parameter int RA_W   = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iINST_VALID,
  input  logic [15:0]       iINST,
  output logic              oINST_READY,
  output logic              oISSUE_VALID,
  output logic [3:0]        oEXE_CMD,
  output logic [DATA_W-1:0] oSOURCE0,
  output logic [DATA_W-1:0] oSOURCE1,
  output logic [RA_W-1:0]   oDEST,
  input  logic              iWB_VALID,
  input  logic [RA_W-1:0]   iWB_DEST,
  input  logic [DATA_W-1:0] iWB_DATA
);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOADI = 4'hF;

  logic [DATA_W-1:0] regFile [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   effBusy;

  logic [3:0]        op;
  logic [RA_W-1:0]   rd;
  logic [RA_W-1:0]   rs0;
  logic [RA_W-1:0]   rs1;
  logic [DATA_W-1:0] imm8;
  logic              isNop;
  logic              isLoadi;
  logic              hazard;
  logic              transfer;
  logic [DATA_W-1:0] src0Rd;
  logic [DATA_W-1:0] src1Rd;

  assign op      = iINST[15:12];
  assign rd      = RA_W'(iINST[11:8]);
  assign rs0     = RA_W'(iINST[7:4]);
  assign rs1     = RA_W'(iINST[3:0]);
  assign imm8    = DATA_W'(iINST[7:0]);
  assign isNop   = (op == OP_NOP);
  assign isLoadi = (op == OP_LOADI);

  // A writeback landing this cycle releases its register immediately (bypass).
  always_comb begin
    effBusy = busy;
    if (iWB_VALID) effBusy[iWB_DEST] = 1'b0;
    effBusy[0] = 1'b0;
  end

  always_comb begin
    hazard = 1'b0;
    if (!isNop) begin
      hazard = effBusy[rd];
      if (!isLoadi) hazard = hazard | effBusy[rs0] | effBusy[rs1];
    end
  end

  // Fetch handshake: a word moves when iINST_VALID & oINST_READY on a posedge.
  // Ready is a function of iINST, so fetch holds iINST while valid & ~ready.
  // Execute has no backpressure: oISSUE_VALID is a one-cycle strobe.
  assign oINST_READY = iRST & ~hazard;
  assign transfer    = iINST_VALID & oINST_READY;

  // Write-first operand read so an instruction released by a writeback sees its data.
  always_comb begin
    src0Rd = regFile[rs0];
    if (rs0 == '0) src0Rd = '0;
    else if (iWB_VALID && iWB_DEST == rs0) src0Rd = iWB_DATA;
    src1Rd = regFile[rs1];
    if (rs1 == '0) src1Rd = '0;
    else if (iWB_VALID && iWB_DEST == rs1) src1Rd = iWB_DATA;
  end

  // Clear-then-set ordering lets a newly issued writer keep its busy bit.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int i = 0; i < NREG; i++) regFile[i] <= '0;
      busy <= '0;
    end else begin
      if (iWB_VALID) begin
        busy[iWB_DEST] <= 1'b0;
        if (iWB_DEST != '0) regFile[iWB_DEST] <= iWB_DATA;
      end
      if (transfer && !isNop && rd != '0) busy[rd] <= 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oISSUE_VALID <= 1'b0;
      oEXE_CMD     <= '0;
      oSOURCE0     <= '0;
      oSOURCE1     <= '0;
      oDEST        <= '0;
    end else begin
      oISSUE_VALID <= transfer;
      if (transfer) begin
        oEXE_CMD <= op;
        oDEST    <= rd;
        oSOURCE0 <= isLoadi ? imm8 : src0Rd;
        oSOURCE1 <= isLoadi ? '0 : src1Rd;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: a register/busy-table model checked every cycle,
// plus directed vectors with literal expectations.
module tb_decode_issue;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iINST_VALID = 1'b0;
  logic [15:0] iINST = '0;
  logic        oINST_READY;
  logic        oISSUE_VALID;
  logic [3:0]  oEXE_CMD;
  logic [7:0]  oSOURCE0;
  logic [7:0]  oSOURCE1;
  logic [3:0]  oDEST;
  logic        iWB_VALID = 1'b0;
  logic [3:0]  iWB_DEST = '0;
  logic [7:0]  iWB_DATA = '0;

  decode_issue #(.DATA_W(8), .NREG(16), .RA_W(4)) dut (
    .iCLK(iCLK), .iRST(iRST), .iINST_VALID(iINST_VALID), .iINST(iINST),
    .oINST_READY(oINST_READY), .oISSUE_VALID(oISSUE_VALID), .oEXE_CMD(oEXE_CMD),
    .oSOURCE0(oSOURCE0), .oSOURCE1(oSOURCE1), .oDEST(oDEST),
    .iWB_VALID(iWB_VALID), .iWB_DEST(iWB_DEST), .iWB_DATA(iWB_DATA)
  );

  always #5 iCLK = ~iCLK;

  int checksTotal = 0;
  int checksPassed = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Model: architectural registers, pending-writer table and the expected issue slot.
  logic [7:0] mReg [16];
  bit         mBusy [16];
  bit         eValid;
  logic [3:0] eCmd;
  logic [7:0] eSrc0;
  logic [7:0] eSrc1;
  logic [3:0] eDest;
  bit         take;

  function automatic bit pendingNow(input logic [3:0] r);
    return (r != 4'd0) && mBusy[r] && !(iWB_VALID && iWB_DEST == r);
  endfunction

  function automatic bit modelReady();
    logic [3:0] op;
    op = iINST[15:12];
    if (!iRST) return 1'b0;
    if (op == 4'h0) return 1'b1;
    if (pendingNow(iINST[11:8])) return 1'b0;
    if (op == 4'hF) return 1'b1;
    return !(pendingNow(iINST[7:4]) || pendingNow(iINST[3:0]));
  endfunction

  function automatic logic [7:0] operand(input logic [3:0] r);
    if (r == 4'd0) return 8'h00;
    if (iWB_VALID && iWB_DEST == r) return iWB_DATA;
    return mReg[r];
  endfunction

  always @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      foreach (mReg[i]) begin
        mReg[i] = 8'h00;
        mBusy[i] = 1'b0;
      end
      eValid = 1'b0; eCmd = '0; eSrc0 = '0; eSrc1 = '0; eDest = '0;
    end else begin
      take = iINST_VALID && modelReady();
      eValid = take;
      if (take) begin
        eCmd  = iINST[15:12];
        eDest = iINST[11:8];
        if (eCmd == 4'hF) begin
          eSrc0 = iINST[7:0];
          eSrc1 = 8'h00;
        end else begin
          eSrc0 = operand(iINST[7:4]);
          eSrc1 = operand(iINST[3:0]);
        end
      end
      if (iWB_VALID) begin
        mBusy[iWB_DEST] = 1'b0;
        if (iWB_DEST != 4'd0) mReg[iWB_DEST] = iWB_DATA;
      end
      if (take && iINST[15:12] != 4'h0 && iINST[11:8] != 4'd0) mBusy[iINST[11:8]] = 1'b1;
    end
  end

  // Mid-cycle compare against the model.
  always @(negedge iCLK) begin
    check("ready", 32'(oINST_READY), 32'(modelReady()));
    check("issue_valid", 32'(oISSUE_VALID), 32'(eValid));
    check("exe_cmd", 32'(oEXE_CMD), 32'(eCmd));
    check("source0", 32'(oSOURCE0), 32'(eSrc0));
    check("source1", 32'(oSOURCE1), 32'(eSrc1));
    check("dest", 32'(oDEST), 32'(eDest));
  end

  // Snapshot of outputs taken mid-cycle by each step, for the literal checks.
  logic       sReady;
  logic       sValid;
  logic [3:0] sCmd;
  logic [7:0] sSrc0;
  logic [7:0] sSrc1;
  logic [3:0] sDest;

  task automatic step(input bit v, input logic [15:0] inst,
                      input bit wbv, input logic [3:0] wbd, input logic [7:0] wbdat);
    iINST_VALID = v; iINST = inst;
    iWB_VALID = wbv; iWB_DEST = wbd; iWB_DATA = wbdat;
    @(negedge iCLK);
    sReady = oINST_READY; sValid = oISSUE_VALID; sCmd = oEXE_CMD;
    sSrc0 = oSOURCE0; sSrc1 = oSOURCE1; sDest = oDEST;
    @(posedge iCLK);
    #1;
  endtask

  task automatic expectIssue(input string name, input logic [3:0] cmd,
                             input logic [7:0] s0, input logic [7:0] s1, input logic [3:0] d);
    check({name, "_valid"}, 32'(sValid), 32'd1);
    check({name, "_cmd"}, 32'(sCmd), 32'(cmd));
    check({name, "_src0"}, 32'(sSrc0), 32'(s0));
    check({name, "_src1"}, 32'(sSrc1), 32'(s1));
    check({name, "_dest"}, 32'(sDest), 32'(d));
  endtask

  initial begin
    #1 iRST = 1'b0;
    @(posedge iCLK);
    #1;
    // Reset held with a valid LOADI R3,#0x2A offered
    for (int i = 0; i < 3; i++) begin
      step(1, 16'hF32A, 0, 4'd0, 8'h00);
      check("rst_ready", 32'(sReady), 32'd0);
      check("rst_valid", 32'(sValid), 32'd0);
      check("rst_src0", 32'(sSrc0), 32'd0);
    end
    iRST = 1'b1;
    step(1, 16'hF32A, 0, 4'd0, 8'h00);
    check("release_ready", 32'(sReady), 32'd1);

    // RAW: ADD R4,R3,R3 behind LOADI R3
    step(1, 16'h1433, 0, 4'd0, 8'h00);
    check("raw_stall0", 32'(sReady), 32'd0);
    expectIssue("loadi_r3", 4'hF, 8'h2A, 8'h00, 4'd3);
    step(1, 16'h1433, 0, 4'd0, 8'h00);
    check("raw_stall1", 32'(sReady), 32'd0);
    check("raw_no_issue", 32'(sValid), 32'd0);
    step(1, 16'h1433, 1, 4'd3, 8'h2A);
    check("raw_release", 32'(sReady), 32'd1);
    step(0, 16'h0000, 1, 4'd4, 8'h54);
    expectIssue("raw_bypass", 4'h1, 8'h2A, 8'h2A, 4'd4);

    // WAW on R5, with same-cycle writeback and reissue
    step(1, 16'hF501, 0, 4'd0, 8'h00);
    check("waw_first", 32'(sReady), 32'd1);
    step(1, 16'hF502, 0, 4'd0, 8'h00);
    check("waw_stall", 32'(sReady), 32'd0);
    step(1, 16'hF502, 1, 4'd5, 8'h01);
    check("waw_release", 32'(sReady), 32'd1);
    step(1, 16'hF503, 0, 4'd0, 8'h00);
    check("waw_set_wins", 32'(sReady), 32'd0);
    expectIssue("waw_second", 4'hF, 8'h02, 8'h00, 4'd5);
    step(1, 16'hF503, 1, 4'd5, 8'h02);
    step(0, 16'h0000, 1, 4'd5, 8'h03);
    expectIssue("waw_third", 4'hF, 8'h03, 8'h00, 4'd5);

    // R0: LOADI R0 never marks busy, R0 reads zero
    step(1, 16'hF007, 0, 4'd0, 8'h00);
    step(1, 16'h1100, 0, 4'd0, 8'h00);
    check("r0_no_stall", 32'(sReady), 32'd1);
    step(0, 16'h0000, 1, 4'd1, 8'h10);
    expectIssue("r0_sources", 4'h1, 8'h00, 8'h00, 4'd1);

    // Regfile contents, and writeback to a register nobody waits on
    step(1, 16'h2654, 0, 4'd0, 8'h00);
    step(0, 16'h0000, 1, 4'd7, 8'h55);
    expectIssue("regread", 4'h2, 8'h03, 8'h54, 4'd6);
    step(1, 16'h1870, 0, 4'd0, 8'h00);
    step(0, 16'h0000, 1, 4'd6, 8'h00);
    expectIssue("nonbusy_wb", 4'h1, 8'h55, 8'h00, 4'd8);

    // Reset in the middle of a RAW stall
    step(1, 16'hF309, 0, 4'd0, 8'h00);
    step(1, 16'h1933, 0, 4'd0, 8'h00);
    check("mid_stall", 32'(sReady), 32'd0);
    iRST = 1'b0;
    step(1, 16'h1933, 0, 4'd0, 8'h00);
    check("mid_rst_ready", 32'(sReady), 32'd0);
    check("mid_rst_valid", 32'(sValid), 32'd0);
    check("mid_rst_dest", 32'(sDest), 32'd0);
    iRST = 1'b1;
    step(1, 16'h1933, 0, 4'd0, 8'h00);
    check("after_rst_ready", 32'(sReady), 32'd1);
    step(0, 16'h0000, 1, 4'd9, 8'h11);
    expectIssue("after_rst", 4'h1, 8'h00, 8'h00, 4'd9);
    step(1, 16'h1A90, 0, 4'd0, 8'h00);
    step(0, 16'h0000, 0, 4'd0, 8'h00);
    expectIssue("wb_after_rst", 4'h1, 8'h11, 8'h00, 4'd10);
    step(0, 16'h0000, 0, 4'd0, 8'h00);
    check("idle_valid", 32'(sValid), 32'd0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
